demux_1to4: RTL and testbench
=============================

# demux_1to4

Registered 1-to-4 demultiplexer with per-channel traffic counters. It routes a WIDTH-bit input onto one of four output channels, selected by a 2-bit select formed from {s1, s0}, with one clock of latency. Downstream logic uses the one-hot valid flags to detect which channel carried the current beat. It sits between a single-source producer and four consumers.

## Interface

Parameters:
- WIDTH, default 1: data width of d and of y0..y3.
- ZERO_UNSEL, default 1: 1 = unselected outputs are driven to 0; 0 = unselected outputs hold their last value.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- en, input, 1: routing enable; a beat is accepted on an edge where en=1.
- d, input, WIDTH: data to route.
- s0, input, 1: select LSB.
- s1, input, 1: select MSB; sel = {s1, s0}.
- cnt_clr, input, 1: synchronous clear of all channel counters.
- y0, output, WIDTH: channel 0 data (sel=00).
- y1, output, WIDTH: channel 1 data (sel=01).
- y2, output, WIDTH: channel 2 data (sel=10).
- y3, output, WIDTH: channel 3 data (sel=11).
- y_valid, output, 4: one-hot beat flag; bit i is set for channel i.
- cnt0..cnt3, output, 8 each: saturating count of beats routed to each channel.

## Operation

- sel = {s1, s0} is sampled together with d and en on each rising clk edge.
- Edge with en=1:
  - y[sel] <= d.
  - Other channels <= 0 when ZERO_UNSEL=1; otherwise they hold.
  - y_valid <= 4'b0001 << sel.
  - cnt[sel] increments by 1 and saturates at 8'hFF; other counters are unchanged.
- Edge with en=0:
  - y_valid <= 0.
  - All y outputs <= 0 when ZERO_UNSEL=1; otherwise they hold.
  - Counters are unchanged.
- cnt_clr=1 on an edge sets all four counters to 0. Clear beats a simultaneous increment, so a beat in the clear cycle is not counted. Data and y_valid are unaffected by cnt_clr.
- y_valid is never multi-hot.
- All outputs are registered; there is no combinational path from inputs to outputs.
- No X handling: sel always decodes to exactly one channel.

## Timing

- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one beat per cycle; the select may change every cycle.
- Reset values, applied asynchronously while rst_n=0: y0..y3=0, y_valid=0, cnt0..cnt3=0.
- Reset assertion mid-stream clears all state immediately, regardless of the clock.
- Reset deassertion: the first beat is captured on the first rising edge with rst_n=1.
- Counters saturate at 255 and do not wrap.

## Test plan

- Select sweep, d=1, en=1, ZERO_UNSEL=1, sel 00, 01, 10, 11 on consecutive cycles:
  - each cycle, exactly one of y0..y3 = 1 and the rest = 0;
  - y_valid = 0001, 0010, 0100, 1000;
  - after the sweep, every counter = 1.
- Hold mode, ZERO_UNSEL=0, WIDTH=8:
  - route A5 to ch0, then 3C to ch2;
  - required: y0 stays A5, y2=3C, y1=y3=0;
  - then en=0: all y outputs hold and y_valid=0.
- Saturation: 300 beats to ch1 -> cnt1=255, others 0. Then cnt_clr together with a beat on ch1 -> cnt1=0 the next cycle.
- Async reset: assert rst_n=0 between clock edges during traffic -> all outputs are 0 immediately; the first post-release beat appears one cycle later.
- Back-to-back select change with en=1, alternating sel 00 and 11 for 8 cycles -> y0 and y3 toggle one cycle delayed, cnt0=cnt3=4.

Source files
------------

// File: rtl/demux_1to4.sv
// demux_1to4: registered 1-to-4 demultiplexer with per-channel beat counters.
//
// Routes d onto one of four channels selected by {s1, s0}, with one cycle of
// latency. A one-hot y_valid flag marks the channel that carried the beat.
// Each channel has a saturating 8-bit counter of the beats routed to it.
//
// Parameters:
//   WIDTH      - data width of d and y0..y3
//   ZERO_UNSEL - 1: unselected channels are driven to 0; 0: they hold
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   en       - routing enable; a beat is accepted on an edge with en=1
//   d        - data to route
//   s0, s1   - channel select, sel = {s1, s0}
//   cnt_clr  - synchronous clear of all counters (wins over an increment)
//   y0..y3   - registered channel data
//   y_valid  - registered one-hot beat flag, bit i for channel i
//   cnt0..3  - saturating beat counters per channel
module demux_1to4 #(
  parameter int WIDTH      = 1,
  parameter bit ZERO_UNSEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             s0,
  input  logic             s1,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] y_q   [4];
  logic [7:0]       cnt_q [4];
  logic [3:0]       valid_q;

  assign sel = {s1, s0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        y_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q <= en ? (4'b0001 << sel) : 4'b0000;

      for (int unsigned i = 0; i < 4; i++) begin
        if (en && (sel == 2'(i))) begin
          y_q[i] <= d;
        end else if (ZERO_UNSEL) begin
          y_q[i] <= '0;
        end
      end

      // Clear takes priority, so a beat in the clear cycle is not counted.
      for (int unsigned i = 0; i < 4; i++) begin
        if (cnt_clr) begin
          cnt_q[i] <= '0;
        end else if (en && (sel == 2'(i)) && (cnt_q[i] != 8'hFF)) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign y0      = y_q[0];
  assign y1      = y_q[1];
  assign y2      = y_q[2];
  assign y3      = y_q[3];
  assign y_valid = valid_q;
  assign cnt0    = cnt_q[0];
  assign cnt1    = cnt_q[1];
  assign cnt2    = cnt_q[2];
  assign cnt3    = cnt_q[3];

endmodule

// File: tb/tb_demux_1to4.sv
// tb_demux_1to4: scoreboard bench for demux_1to4.
//
// Two instances share one stimulus stream: dut_z (ZERO_UNSEL=1) and dut_h
// (ZERO_UNSEL=0), both WIDTH=8. The stimulus process updates a per-channel
// reference model and pushes the expected outputs into a queue; a monitor
// pops one entry per clock while out of reset and compares.
module tb_demux_1to4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] d = '0;
  logic       s0 = 1'b0;
  logic       s1 = 1'b0;
  logic       cnt_clr = 1'b0;

  logic [7:0] z_y0, z_y1, z_y2, z_y3, z_c0, z_c1, z_c2, z_c3;
  logic [7:0] h_y0, h_y1, h_y2, h_y3, h_c0, h_c1, h_c2, h_c3;
  logic [3:0] z_v, h_v;

  always #5 clk = ~clk;

  demux_1to4 #(.WIDTH(8), .ZERO_UNSEL(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .s0(s0), .s1(s1),
    .cnt_clr(cnt_clr),
    .y0(z_y0), .y1(z_y1), .y2(z_y2), .y3(z_y3), .y_valid(z_v),
    .cnt0(z_c0), .cnt1(z_c1), .cnt2(z_c2), .cnt3(z_c3)
  );

  demux_1to4 #(.WIDTH(8), .ZERO_UNSEL(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .s0(s0), .s1(s1),
    .cnt_clr(cnt_clr),
    .y0(h_y0), .y1(h_y1), .y2(h_y2), .y3(h_y3), .y_valid(h_v),
    .cnt0(h_c0), .cnt1(h_c1), .cnt2(h_c2), .cnt3(h_c3)
  );

  typedef struct packed {
    logic [3:0][7:0] yz;
    logic [3:0][7:0] yh;
    logic [3:0]      v;
    logic [3:0][7:0] c;
  } exp_t;

  exp_t q[$];

  // Reference model state
  logic [3:0][7:0] m_yh;
  int              m_cnt[4];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_yh = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Issue one cycle of stimulus and push the expected post-edge outputs.
  task automatic beat(input bit e, input bit [1:0] s, input logic [7:0] dv,
                      input bit clr);
    exp_t x;
    @(negedge clk);
    en = e; {s1, s0} = s; d = dv; cnt_clr = clr;
    for (int ch = 0; ch < 4; ch++) begin
      bit hit;
      hit = e && (int'(s) == ch);
      x.yz[ch] = hit ? dv : 8'h00;
      if (hit) m_yh[ch] = dv;
    end
    x.yh = m_yh;
    x.v  = e ? 4'(1 << s) : 4'b0000;
    if (clr) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (e && m_cnt[s] < 255) begin
      m_cnt[s] = m_cnt[s] + 1;
    end
    for (int i = 0; i < 4; i++) x.c[i] = 8'(m_cnt[i]);
    q.push_back(x);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_z_y"}, {z_y3, z_y2, z_y1, z_y0}, 32'h0);
    check({tag, "_h_y"}, {h_y3, h_y2, h_y1, h_y0}, 32'h0);
    check({tag, "_z_cnt"}, {z_c3, z_c2, z_c1, z_c0}, 32'h0);
    check({tag, "_h_cnt"}, {h_c3, h_c2, h_c1, h_c0}, 32'h0);
    check({tag, "_valid"}, {24'h0, h_v, z_v}, 32'h0);
  endtask

  // Assert reset between edges during traffic, check it takes effect at
  // once, then release just after a rising edge.
  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: one expected entry per clock edge taken out of reset.
  initial begin
    exp_t x;
    logic [3:0][7:0] ayz, ayh, acz, ach;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        #1;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty: got 0 entries required 1 at %0t", $time);
        end else begin
          x   = q.pop_front();
          ayz = {z_y3, z_y2, z_y1, z_y0};
          ayh = {h_y3, h_y2, h_y1, h_y0};
          acz = {z_c3, z_c2, z_c1, z_c0};
          ach = {h_c3, h_c2, h_c1, h_c0};
          for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("zero_y%0d", ch), 32'(ayz[ch]), 32'(x.yz[ch]));
            check($sformatf("hold_y%0d", ch), 32'(ayh[ch]), 32'(x.yh[ch]));
            check($sformatf("zero_cnt%0d", ch), 32'(acz[ch]), 32'(x.c[ch]));
            check($sformatf("hold_cnt%0d", ch), 32'(ach[ch]), 32'(x.c[ch]));
          end
          check("zero_valid", 32'(z_v), 32'(x.v));
          check("hold_valid", 32'(h_v), 32'(x.v));
          check("valid_onehot", 32'($countones(z_v) <= 1), 32'd1);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2 check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Select sweep with d=1
    for (int s = 0; s < 4; s++) beat(1'b1, 2'(s), 8'h01, 1'b0);

    // Hold behaviour: A5 to ch0, 3C to ch2, then idle
    beat(1'b1, 2'd0, 8'hA5, 1'b0);
    beat(1'b1, 2'd2, 8'h3C, 1'b0);
    beat(1'b0, 2'd1, 8'hFF, 1'b0);
    beat(1'b0, 2'd3, 8'h77, 1'b0);

    // Alternate sel 00 / 11 after clearing counters
    beat(1'b0, 2'd0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++)
      beat(1'b1, (i % 2 == 0) ? 2'd0 : 2'd3, 8'($urandom_range(0, 255)), 1'b0);

    // Saturation on ch1, then clear together with a beat on ch1
    beat(1'b0, 2'd0, 8'h00, 1'b1);
    for (int i = 0; i < 300; i++) beat(1'b1, 2'd1, 8'(i), 1'b0);
    beat(1'b1, 2'd1, 8'h5A, 1'b1);
    beat(1'b0, 2'd0, 8'h00, 1'b0);

    // Random traffic
    for (int i = 0; i < 200; i++)
      beat($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);

    // Reset in the middle of traffic, then resume
    mid_reset();
    beat(1'b1, 2'd3, 8'hC3, 1'b0);
    for (int i = 0; i < 100; i++)
      beat($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), $urandom_range(0, 31) == 0);

    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
